// File: rtl/execute_cycle.sv
// Execute stage of the five-stage RISC-V pipeline: operand forwarding, ALU,
// branch resolution and the EX/MEM pipeline register.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [4:0]  RD_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] w_src_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_result;
  logic        w_zero;

  logic        r_reg_write;
  logic        r_mem_write;
  logic        r_result_src;
  logic [4:0]  r_rd;
  logic [31:0] r_alu_result;
  logic [31:0] r_write_data;
  logic [31:0] r_pc_plus4;

  // Forward select: 01 = writeback result, 10 = this stage's registered ALU result.
  always_comb begin
    w_src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = r_alu_result;
      default: w_src_a = RD1_E;
    endcase
  end

  always_comb begin
    w_fwd_b = RD2_E;
    case (ForwardB_E)
      2'b01:   w_fwd_b = ResultW;
      2'b10:   w_fwd_b = r_alu_result;
      default: w_fwd_b = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

  always_comb begin
    w_alu_result = 32'h0;
    case (ALUControlE)
      3'b000:  w_alu_result = w_src_a + w_src_b;
      3'b001:  w_alu_result = w_src_a - w_src_b;
      3'b010:  w_alu_result = w_src_a & w_src_b;
      3'b011:  w_alu_result = w_src_a | w_src_b;
      3'b101:  w_alu_result = {31'b0, $signed(w_src_a) < $signed(w_src_b)};
      default: w_alu_result = 32'h0;
    endcase
  end

  assign w_zero    = (w_alu_result == 32'h0);
  assign PCSrcE    = BranchE & w_zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // No stall: the EX/MEM register loads every cycle; store data is the forwarded rs2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_rd         <= 5'd0;
      r_alu_result <= 32'h0;
      r_write_data <= 32'h0;
      r_pc_plus4   <= 32'h0;
    end else begin
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
      r_rd         <= RD_E;
      r_alu_result <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_pc_plus4   <= PCPlus4E;
    end
  end

  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign ResultSrcM = r_result_src;
  assign RD_M       = r_rd;
  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed and random vectors, reference model feeds
// an expected queue that a monitor drains one entry per rising edge.
module tb_execute_cycle;

  localparam int W = 104;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  logic [W-1:0] exp_q[$];
  logic [31:0]  model_alu_m;
  int           n_vec;
  int           n_miss;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_outputs();
    return {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};
  endfunction

  // Reference model
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val,
                                       input logic [31:0] wb, input logic [31:0] prev);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return prev;
    return reg_val;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (op == 3'd0) return a + b;
    if (op == 3'd1) return a - b;
    if (op == 3'd2) return a & b;
    if (op == 3'd3) return a | b;
    if (op == 3'd5) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic model(output logic [W-1:0] e, output logic pc_src, output logic [31:0] tgt);
    logic [31:0] a, fb, b, res;
    a   = pick(ForwardA_E, RD1_E, ResultW, model_alu_m);
    fb  = pick(ForwardB_E, RD2_E, ResultW, model_alu_m);
    b   = ALUSrcE ? Imm_Ext_E : fb;
    res = alu_ref(ALUControlE, a, b);
    pc_src = BranchE && (res == 32'd0);
    tgt    = PCE + Imm_Ext_E;
    e = {RegWriteE, MemWriteE, ResultSrcE, RD_E, res, fb, PCPlus4E};
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_expected();
    logic [W-1:0] e;
    logic         s;
    logic [31:0]  t;
    model(e, s, t);
    exp_q.push_back(e);
    model_alu_m = e[95:64];
  endtask

  // Driver: inputs are already set at the negedge; check combinational outputs and queue the M result.
  task automatic issue();
    logic [W-1:0] e;
    logic         s;
    logic [31:0]  t;
    #1;
    n_vec++;
    model(e, s, t);
    check1("pcsrc", {31'b0, PCSrcE}, {31'b0, s});
    check1("pctarget", PCTargetE, t);
    if (rst) begin
      exp_q.push_back(e);
      model_alu_m = e[95:64];
    end
  endtask

  task automatic rand_fields();
    RegWriteE   = 1'($urandom_range(0, 1));
    ALUSrcE     = 1'($urandom_range(0, 1));
    MemWriteE   = 1'($urandom_range(0, 1));
    ResultSrcE  = 1'($urandom_range(0, 1));
    BranchE     = 1'($urandom_range(0, 1));
    ALUControlE = 3'($urandom_range(0, 7));
    RD1_E       = $urandom;
    RD2_E       = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
    Imm_Ext_E   = $urandom;
    RD_E        = 5'($urandom_range(0, 31));
    PCE         = $urandom;
    PCPlus4E    = PCE + 32'd4;
    ForwardA_E  = 2'($urandom_range(0, 3));
    ForwardB_E  = 2'($urandom_range(0, 3));
    ResultW     = $urandom;
  endtask

  task automatic set_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rand_fields();
    ALUControlE = op;
    RD1_E = a;
    RD2_E = b;
    ALUSrcE = 1'b0;
    ForwardA_E = 2'd0;
    ForwardB_E = 2'd0;
  endtask

  task automatic check_reset_zero();
    n_vec++;
    if (m_outputs() !== '0) begin
      n_miss++;
      $display("FAIL reset_zero: got %h expected 0 at %0t", m_outputs(), $time);
    end
  endtask

  // Assert reset between edges, check M outputs clear immediately, run one
  // forwarded vector under reset, then release between edges.
  task automatic reset_cycle();
    #2 rst = 1'b0;
    exp_q.delete();
    model_alu_m = 32'd0;
    #1 check_reset_zero();
    @(negedge clk);
    rand_fields();
    ForwardA_E = 2'd2;
    ForwardB_E = 2'd2;
    ALUSrcE = 1'b0;
    ALUControlE = 3'd0;
    issue();
    @(negedge clk);
    #1 check_reset_zero();
    #1 rst = 1'b1;
    push_expected();
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (m_outputs() !== e) begin
          n_miss++;
          $display("FAIL mstage: got %h expected %h at %0t", m_outputs(), e, $time);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_miss = 0;
    model_alu_m = 32'd0;
    rst = 1'b0;
    rand_fields();
    #2 check_reset_zero();
    @(negedge clk);
    rand_fields();
    ForwardA_E = 2'd2;
    ForwardB_E = 2'd2;
    issue();
    #1 rst = 1'b1;
    push_expected();

    @(negedge clk); set_alu(3'd0, 32'd7, 32'd5); issue();
    @(negedge clk); set_alu(3'd1, 32'd5, 32'd7); issue();
    @(negedge clk); set_alu(3'd2, 32'hF0F0F0F0, 32'h0FF00FF0); issue();
    @(negedge clk); set_alu(3'd3, 32'hF0F0F0F0, 32'h0FF00FF0); issue();
    @(negedge clk); set_alu(3'd5, 32'hFFFFFFFF, 32'd1); issue();
    @(negedge clk); set_alu(3'd5, 32'd1, 32'hFFFFFFFF); issue();
    @(negedge clk); set_alu(3'd7, 32'd3, 32'd9); issue();
    @(negedge clk); set_alu(3'd0, 32'd100, 32'h55);
    ALUSrcE = 1'b1; Imm_Ext_E = 32'hFFFFFFFC; issue();
    @(negedge clk); set_alu(3'd0, 32'd4, 32'd6); issue();
    @(negedge clk); set_alu(3'd0, 32'd0, 32'd0);
    ForwardA_E = 2'd2; ALUSrcE = 1'b1; Imm_Ext_E = 32'd3; issue();
    @(negedge clk); set_alu(3'd0, 32'd1, 32'd2);
    ForwardB_E = 2'd1; ResultW = 32'h20; MemWriteE = 1'b1; issue();
    @(negedge clk); set_alu(3'd1, 32'd9, 32'd9);
    BranchE = 1'b1; PCE = 32'h100; Imm_Ext_E = 32'h10; issue();
    @(negedge clk); set_alu(3'd1, 32'd9, 32'd8);
    BranchE = 1'b1; issue();
    @(negedge clk); set_alu(3'd1, 32'd9, 32'd9);
    BranchE = 1'b1; PCE = 32'hFFFFFFF0; Imm_Ext_E = 32'h20; issue();
    @(negedge clk); set_alu(3'd0, 32'h40, 32'h77);
    MemWriteE = 1'b1; RegWriteE = 1'b0; issue();
    @(negedge clk); set_alu(3'd0, 32'h1, 32'h2);
    RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0; BranchE = 1'b0; issue();

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_fields();
      issue();
      if (i == 150) reset_cycle();
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
